// File: rtl/pll_lock_sequencer_if.sv
// Purpose: groups the control, PLL-facing and status signals of pll_lock_sequencer.
// Latency: none; this is wiring only.
// Backpressure: none; every signal is a level.
//
// Ports (modport master = sequencer side, modport slave = controller/PLL side):
//   ENABLE           1  level request, 1 = bring PLL up and keep it up
//   PLL_LOCK         1  raw PLL lock, asynchronous to SCLK
//   PLL_POWERDOWN_N  1  to PLL POWERDOWN_N
//   FAB_RESET_N      1  active-low reset to PLL-clocked fabric logic
//   READY            1  sequencer in RUN
//   FAIL             1  sequencer in FAILED
//   RETRY_CNT        4  failed lock attempts in the current sequence
//   LOSS_CNT         8  lock-loss events seen in RUN, saturating
//   STATE            3  0 IDLE, 1 PD_HOLD, 2 LOCK_WAIT, 3 STABLE, 4 RUN, 5 FAILED
interface pll_lock_sequencer_if;
   logic       ENABLE;
   logic       PLL_LOCK;
   logic       PLL_POWERDOWN_N;
   logic       FAB_RESET_N;
   logic       READY;
   logic       FAIL;
   logic [3:0] RETRY_CNT;
   logic [7:0] LOSS_CNT;
   logic [2:0] STATE;

   modport master (
      input  ENABLE,
      input  PLL_LOCK,
      output PLL_POWERDOWN_N,
      output FAB_RESET_N,
      output READY,
      output FAIL,
      output RETRY_CNT,
      output LOSS_CNT,
      output STATE
   );

   modport slave (
      output ENABLE,
      output PLL_LOCK,
      input  PLL_POWERDOWN_N,
      input  FAB_RESET_N,
      input  READY,
      input  FAIL,
      input  RETRY_CNT,
      input  LOSS_CNT,
      input  STATE
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Purpose: power-up sequencer for a fabric CCC/PLL: powerdown hold, lock wait with retries, stability qualification, lock-loss monitoring.
// Latency: all outputs registered from the next state; PLL_POWERDOWN_N rises PD_HOLD_CYCLES+1 edges after ENABLE, FAB_RESET_N STABLE_CYCLES+1 edges after synced lock.
// Backpressure: none; ENABLE is a level request and every output is a status level.
//
// Ports:
//   SCLK    free-running system clock, independent of the PLL outputs
//   RESETN  asynchronous active-low reset; clears state, all outputs and LOSS_CNT
//   seq     pll_lock_sequencer_if.master (ENABLE, PLL_LOCK in; PLL_POWERDOWN_N,
//           FAB_RESET_N, READY, FAIL, RETRY_CNT, LOSS_CNT, STATE out)
//
// Build option: define PLL_SEQ_AUTO_RELOCK_EN to re-sequence automatically on lock
// loss in RUN; when undefined, lock loss in RUN goes to FAILED until ENABLE drops.
module pll_lock_sequencer #(
   parameter int PD_HOLD_CYCLES = 64,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int STABLE_CYCLES  = 256,
   parameter int MAX_RETRIES    = 3
) (
   input  logic                 SCLK,
   input  logic                 RESETN,
   pll_lock_sequencer_if.master seq
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PD_HOLD   = 3'd1,
      ST_LOCK_WAIT = 3'd2,
      ST_STABLE    = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAILED    = 3'd5
   } state_t;

   // Terminal counts: the shared counter starts at 0 on state entry, so a state
   // that must last N cycles exits when the counter reads N-1.
   localparam logic [15:0] PD_LAST     = 16'(PD_HOLD_CYCLES - 1);
   localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
   localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  retry_q, retry_d;
   logic [7:0]  loss_q, loss_d;
   logic        lock_meta_q, lock_s_q;
   logic        pd_n_q, pd_n_d;
   logic        fab_reset_n_q, fab_reset_n_d;
   logic        ready_q, ready_d;
   logic        fail_q, fail_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      loss_d  = loss_q;

      case (state_q)
         ST_IDLE: begin
            if (seq.ENABLE) state_d = ST_PD_HOLD;
         end
         ST_PD_HOLD: begin
            if (cnt_q == PD_LAST) state_d = ST_LOCK_WAIT;
         end
         ST_LOCK_WAIT: begin
            // Lock is tested first so it wins on the timeout cycle.
            if (lock_s_q) begin
               state_d = ST_STABLE;
            end else if (cnt_q == LOCK_LAST) begin
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 4'd1;
                  state_d = ST_PD_HOLD;
               end else begin
                  state_d = ST_FAILED;
               end
            end
         end
         ST_STABLE: begin
            // A dropout restarts the lock wait without counting a failed attempt.
            if (!lock_s_q) state_d = ST_LOCK_WAIT;
            else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!lock_s_q) begin
               if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
               retry_d = 4'd0;
               state_d = ST_PD_HOLD;
`else
               state_d = ST_FAILED;
`endif
            end
         end
         ST_FAILED: begin
            state_d = ST_FAILED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // ENABLE low overrides every transition. A lock loss coinciding with a
      // shutdown request is not counted: the fabric is being torn down anyway.
      if (!seq.ENABLE) begin
         state_d = ST_IDLE;
         retry_d = 4'd0;
         loss_d  = loss_q;
      end

      // Cleared on every state entry; only the timed states advance it.
      if (state_d != state_q) begin
         cnt_d = 16'd0;
      end else if (state_q == ST_PD_HOLD || state_q == ST_LOCK_WAIT || state_q == ST_STABLE) begin
         cnt_d = cnt_q + 16'd1;
      end

      // Outputs decoded from the next state so they move on the same edge as STATE.
      pd_n_d        = (state_d == ST_LOCK_WAIT) || (state_d == ST_STABLE) || (state_d == ST_RUN);
      fab_reset_n_d = (state_d == ST_RUN);
      ready_d       = (state_d == ST_RUN);
      fail_d        = (state_d == ST_FAILED);
   end

   always_ff @(posedge SCLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 16'd0;
         retry_q       <= 4'd0;
         loss_q        <= 8'd0;
         lock_meta_q   <= 1'b0;
         lock_s_q      <= 1'b0;
         pd_n_q        <= 1'b0;
         fab_reset_n_q <= 1'b0;
         ready_q       <= 1'b0;
         fail_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         retry_q       <= retry_d;
         loss_q        <= loss_d;
         // Two-flop synchronizer; raw PLL_LOCK is used nowhere else.
         lock_meta_q   <= seq.PLL_LOCK;
         lock_s_q      <= lock_meta_q;
         pd_n_q        <= pd_n_d;
         fab_reset_n_q <= fab_reset_n_d;
         ready_q       <= ready_d;
         fail_q        <= fail_d;
      end
   end

   assign seq.PLL_POWERDOWN_N = pd_n_q;
   assign seq.FAB_RESET_N     = fab_reset_n_q;
   assign seq.READY           = ready_q;
   assign seq.FAIL            = fail_q;
   assign seq.RETRY_CNT       = retry_q;
   assign seq.LOSS_CNT        = loss_q;
   assign seq.STATE           = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Purpose: directed, table-driven bench for pll_lock_sequencer with small timing parameters.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 time unit after the next.
// Backpressure: none.
module tb_pll_lock_sequencer;

   localparam int P_PD = 4;
   localparam int P_TO = 20;
   localparam int P_ST = 8;
   localparam int P_MR = 2;

   localparam int IDL = 0;
   localparam int PDH = 1;
   localparam int LWT = 2;
   localparam int STB = 3;
   localparam int RUN = 4;
   localparam int FLD = 5;

   logic SCLK   = 1'b0;
   logic RESETN = 1'b0;

   pll_lock_sequencer_if bus ();

   pll_lock_sequencer #(
      .PD_HOLD_CYCLES (P_PD),
      .LOCK_TIMEOUT   (P_TO),
      .STABLE_CYCLES  (P_ST),
      .MAX_RETRIES    (P_MR)
   ) dut (
      .SCLK   (SCLK),
      .RESETN (RESETN),
      .seq    (bus)
   );

   always #5 SCLK = ~SCLK;

   typedef struct packed {
      logic [2:0] state;
      logic       pd_n;
      logic       fab;
      logic       rdy;
      logic       fail;
      logic [3:0] retry;
      logic [7:0] loss;
   } obs_t;

   typedef struct {
      int   n;
      logic en;
      logic lk;
      obs_t exp;
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Expected outputs per state as the sequencer's output table defines them.
   function automatic obs_t e(int st, int retry, int loss);
      obs_t o;
      o.state = 3'(st);
      o.pd_n  = (st == LWT) || (st == STB) || (st == RUN);
      o.fab   = (st == RUN);
      o.rdy   = (st == RUN);
      o.fail  = (st == FLD);
      o.retry = 4'(retry);
      o.loss  = 8'(loss);
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.state = bus.STATE;
      o.pd_n  = bus.PLL_POWERDOWN_N;
      o.fab   = bus.FAB_RESET_N;
      o.rdy   = bus.READY;
      o.fail  = bus.FAIL;
      o.retry = bus.RETRY_CNT;
      o.loss  = bus.LOSS_CNT;
      return o;
   endfunction

   task automatic add(input int n, input logic en, input logic lk, input int st, input int r, input int l);
      vec_t v;
      v.n   = n;
      v.en  = en;
      v.lk  = lk;
      v.exp = e(st, r, l);
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input obs_t exp);
      obs_t act;
      act = sample();
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got state=%0d pd_n=%b fab=%b rdy=%b fail=%b retry=%0d loss=%0d, want state=%0d pd_n=%b fab=%b rdy=%b fail=%b retry=%0d loss=%0d",
                  name, act.state, act.pd_n, act.fab, act.rdy, act.fail, act.retry, act.loss,
                  exp.state, exp.pd_n, exp.fab, exp.rdy, exp.fail, exp.retry, exp.loss);
      end
   endtask

   task automatic step();
      @(posedge SCLK);
      #1;
   endtask

   task automatic wait_state(input int st, input int budget, input string name);
      int  k;
      bit  ok;
      k  = 0;
      ok = 1'b0;
      while (!ok && k < budget) begin
         step();
         k++;
         if (bus.STATE == 3'(st)) ok = 1'b1;
      end
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: state=%0d after %0d cycles, want state=%0d", name, bus.STATE, budget, st);
      end
   endtask

   initial begin
      int exp_loss;

      // Nominal bring-up: lock first sampled 10 edges after PLL_POWERDOWN_N rises.
      add(1, 1, 0, PDH, 0, 0);
      add(3, 1, 0, PDH, 0, 0);
      add(1, 1, 0, LWT, 0, 0);
      add(9, 1, 0, LWT, 0, 0);
      add(2, 1, 1, LWT, 0, 0);
      add(8, 1, 1, STB, 0, 0);
      add(1, 1, 1, RUN, 0, 0);
      add(3, 1, 1, RUN, 0, 0);
      // ENABLE low mid-RUN.
      add(1, 0, 1, IDL, 0, 0);
      add(2, 0, 0, IDL, 0, 0);
      // Glitchy lock: 5 high, 1 low, then high.
      add(4, 1, 0, PDH, 0, 0);
      add(1, 1, 0, LWT, 0, 0);
      add(2, 1, 0, LWT, 0, 0);
      add(2, 1, 1, LWT, 0, 0);
      add(3, 1, 1, STB, 0, 0);
      add(1, 1, 0, STB, 0, 0);
      add(1, 1, 1, STB, 0, 0);
      add(1, 1, 1, LWT, 0, 0);
      add(8, 1, 1, STB, 0, 0);
      add(1, 1, 1, RUN, 0, 0);
      // Lock dropped for 3 cycles in RUN.
      add(2, 1, 0, RUN, 0, 0);
`ifdef PLL_SEQ_AUTO_RELOCK_EN
      add(1, 1, 0, PDH, 0, 1);
      add(3, 1, 1, PDH, 0, 1);
      add(1, 1, 1, LWT, 0, 1);
      add(8, 1, 1, STB, 0, 1);
      add(1, 1, 1, RUN, 0, 1);
      add(2, 1, 1, RUN, 0, 1);
`else
      add(1, 1, 0, FLD, 0, 1);
      add(4, 1, 1, FLD, 0, 1);
`endif
      add(1, 0, 0, IDL, 0, 1);
      add(2, 0, 0, IDL, 0, 1);
      // Timeout and retries with lock held low, then FAILED and ENABLE release.
      for (int r = 0; r <= P_MR; r++) begin
         add(4, 1, 0, PDH, r, 1);
         add(P_TO, 1, 0, LWT, r, 1);
      end
      add(3, 1, 0, FLD, P_MR, 1);
      add(1, 0, 0, IDL, 0, 1);
      // ENABLE low mid-LOCK_WAIT.
      add(4, 1, 0, PDH, 0, 1);
      add(3, 1, 0, LWT, 0, 1);
      add(1, 0, 0, IDL, 0, 1);
      // One-cycle ENABLE pulse.
      add(1, 1, 0, PDH, 0, 1);
      add(2, 0, 0, IDL, 0, 1);
      // Synced lock arrives exactly on the timeout cycle: lock wins.
      add(4, 1, 0, PDH, 0, 1);
      add(18, 1, 0, LWT, 0, 1);
      add(2, 1, 1, LWT, 0, 1);
      add(1, 1, 1, STB, 0, 1);
      add(2, 1, 1, STB, 0, 1);

      bus.ENABLE   = 1'b0;
      bus.PLL_LOCK = 1'b0;
      step();
      step();
      check("reset_state", e(IDL, 0, 0));
      RESETN = 1'b1;

      foreach (tbl[i]) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            bus.ENABLE   = tbl[i].en;
            bus.PLL_LOCK = tbl[i].lk;
            step();
            check($sformatf("vec%0d.%0d", i, k), tbl[i].exp);
         end
      end

      // Asynchronous reset for part of a cycle while in STABLE.
      check("pre_reset_stable", e(STB, 0, 1));
      #2;
      RESETN     = 1'b0;
      bus.ENABLE = 1'b0;
      #1;
      check("async_reset_immediate", e(IDL, 0, 0));
      #2;
      RESETN = 1'b1;
      step();
      check("after_reset_idle", e(IDL, 0, 0));

      // Repeated lock losses in RUN to saturate LOSS_CNT.
      exp_loss     = 0;
      bus.PLL_LOCK = 1'b1;
      bus.ENABLE   = 1'b1;
      wait_state(RUN, 60, "bringup_run");
      for (int i = 0; i < 256; i++) begin
         bus.PLL_LOCK = 1'b0;
         step();
         step();
         step();
         exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
         n_chk++;
         if (bus.LOSS_CNT !== 8'(exp_loss)) begin
            n_fail++;
            $display("FAIL loss_cnt[%0d]: got %0d, want %0d", i, bus.LOSS_CNT, exp_loss);
         end
`ifndef PLL_SEQ_AUTO_RELOCK_EN
         bus.ENABLE = 1'b0;
         step();
         bus.ENABLE = 1'b1;
`endif
         bus.PLL_LOCK = 1'b1;
         wait_state(RUN, 60, $sformatf("relock_run[%0d]", i));
      end
      bus.ENABLE = 1'b0;
      step();
      check("loss_saturated_idle", e(IDL, 0, 255));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
